stream_demux: RTL and testbench
===============================

# stream_demux

Registered 1-to-2 AXI-stream demultiplexer: routes beats from upstream port `c` to downstream port `a` or `b` under `sel`, with a registered skid stage on each output so every port is fully registered and throughput is one beat per cycle. The routing decision is locked for the duration of a packet (framed by `last`), so a packet never splits across outputs. It is the split-side counterpart of the join/fork stream mux and sits at fork points of stream pipelines.

## Interface
- `DATA_WD`, 4, payload width in bits
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  synchronous reset, active-high
- `sel`  in  1  route select: 0 → `a`, 1 → `b`; qualified with `c_valid`
- `c_data`  in  DATA_WD  upstream payload
- `c_valid`  in  1  upstream valid
- `c_last`  in  1  upstream end-of-packet marker
- `c_ready`  out  1  upstream ready
- `a_data` / `b_data`  out  DATA_WD  downstream payload
- `a_valid` / `b_valid`  out  1  downstream valid
- `a_last` / `b_last`  out  1  downstream end-of-packet
- `a_ready` / `b_ready`  in  1  downstream ready

## Operation
- Fire events: `c_fire = c_valid & c_ready`; `a_fire`, `b_fire` likewise.
- Route `r`: in IDLE `r = sel`; in LOCK_A `r = 0`; in LOCK_B `r = 1`. `sel` is ignored outside IDLE.
- `c_ready = in_ready` of the skid stage selected by `r`. The unselected stage receives no write.
- Lock FSM (states IDLE, LOCK_A, LOCK_B):
  - IDLE, `c_fire & !c_last` → LOCK_A if `r=0`, LOCK_B if `r=1`.
  - IDLE, `c_fire & c_last` (single-beat packet) → stay in IDLE.
  - LOCK_x, `c_fire & c_last` → IDLE; any other case → hold.
- Skid stage, per output, 2 entries (main + skid), each holding `{last, data}`:
  - Write when `r` selects it and `c_fire`; the beat goes to main if main is empty or draining this cycle, otherwise to skid.
  - `in_ready` is registered: `in_ready = !skid_valid`.
  - On an output fire, skid moves to main; if skid is empty, main takes the incoming write or clears.
  - Beats leave in arrival order; no beat is dropped or duplicated.
- The two outputs are independent: a stall on `b` does not block draining of `a`.

## Timing
- Latency: a beat accepted on `c` at edge N is presented on its output from cycle N+1.
- Throughput: 1 beat/cycle sustained when the target output is always ready.
- Backpressure: after the target output stalls, at most 2 beats are buffered. `c_ready` drops in the cycle after the skid entry fills and rises in the cycle after the skid drains.
- The `valid`/`data`/`last` outputs are held stable while `valid & !ready`.
- Reset, while `rst`=1 and on the first edge after: FSM=IDLE, `a_valid`=`b_valid`=0, `a_last`=`b_last`=0, data=0, skid entries empty, `c_ready`=0.
- `c_ready`=1 from the first cycle after `rst` deasserts.
- Reset mid-packet discards all buffered beats and the lock. The next beat is treated as the start of a packet.
- Upstream may toggle `sel` freely mid-packet. It has no effect until the FSM is back in IDLE.

## Configuration
- `STREAM_DEMUX_PKT_LOCK_EN` defined: the packet lock FSM operates as described above.
- `STREAM_DEMUX_PKT_LOCK_EN` undefined: the FSM is removed and `r = sel` on every beat.
  - `c_last` is still carried to the outputs but does not affect routing.
  - All other behaviour is unchanged.

## Structure
- Shared package `stream_pkg`:
  - lock-state enum `demux_state_t` {IDLE, LOCK_A, LOCK_B}
  - beat struct `{last, data}` parameterised through `DATA_WD`
- Sub-module `stream_skid_buf`:
  - 2-entry registered skid buffer with ports clk/rst/in_*/out_*
  - instantiated twice, once for `a` and once for `b`
- The top level holds the FSM, route mux and write-enable steering.

## Test plan
- Reset: hold `rst`=1 for 3 cycles with `c_valid`=1 → `c_ready`=0, `a_valid`=`b_valid`=0 throughout; `c_ready`=1 in the first cycle after release.
- Packet lock: 4-beat packet, data 1,2,3,4, `last` on beat 4, `sel`=0 on beat 1 then `sel`=1 on beats 2–4 → all four beats appear on `a` in order, `b_valid` never asserts, FSM returns to IDLE.
- Streaming: alternating single-beat packets 5 (`sel`=0), 6 (`sel`=1), both readies tied to 1 → 1 beat/cycle; `a` and `b` each show 1-cycle latency.
- Backpressure: `a_ready`=0, 5 beats offered to `a` → exactly 2 beats accepted and `c_ready`=0. Then `a_ready`=1 → data out in order with no loss or duplication.
- Independence: `b` stalled holding 2 beats, next packet sent to `a` → `a` drains normally and the `b` contents are unchanged.
- Mid-packet reset: pulse `rst` after beat 2 of a `sel`=1 packet → outputs cleared; next beat with `sel`=0 routes to `a`.
- Macro undefined: repeat the packet-lock test → beats 2–4 appear on `b`.

Source files
------------

// File: rtl/stream_pkg.sv
// stream_pkg: shared types for the stream demux and its skid stages.
// The beat width comes from DATA_WD below.
package stream_pkg;

  localparam int unsigned DATA_WD = 4;
  localparam int unsigned BEAT_WD = DATA_WD + 1;

  // Packet-lock state of the demux router.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } demux_state_t;

  // One stream beat as stored in a skid entry.
  typedef struct packed {
    logic               last;
    logic [DATA_WD-1:0] data;
  } beat_t;

  // Route for the current beat: free choice in IDLE, pinned while locked.
  function automatic logic lock_route(input demux_state_t st, input logic sel);
    logic route;
    route = sel;
    if (st == LOCK_A) route = 1'b0;
    if (st == LOCK_B) route = 1'b1;
    return route;
  endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// stream_skid_buf: 2-entry registered skid buffer (main + skid).
// in_ready is registered and equals "skid entry empty"; output is the main entry.
module stream_skid_buf
  import stream_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  in_valid,
  output logic  in_ready,
  input  beat_t in_beat,
  output logic  out_valid,
  input  logic  out_ready,
  output beat_t out_beat
);

  beat_t r_main;
  beat_t r_skid;
  logic  r_main_valid;
  logic  r_skid_valid;
  logic  r_in_ready;

  beat_t w_main_nxt;
  beat_t w_skid_nxt;
  logic  w_main_valid_nxt;
  logic  w_skid_valid_nxt;
  logic  w_wr;
  logic  w_rd;

  assign w_wr = in_valid & r_in_ready;
  assign w_rd = r_main_valid & out_ready;

  // Next state of the two entries: drain refills main from skid first, then from input.
  always_comb begin
    w_main_nxt       = r_main;
    w_skid_nxt       = r_skid;
    w_main_valid_nxt = r_main_valid;
    w_skid_valid_nxt = r_skid_valid;
    if (w_rd) begin
      if (r_skid_valid) begin
        w_main_nxt       = r_skid;
        w_skid_valid_nxt = 1'b0;
        if (w_wr) begin
          w_skid_nxt       = in_beat;
          w_skid_valid_nxt = 1'b1;
        end
      end else if (w_wr) begin
        w_main_nxt = in_beat;
      end else begin
        w_main_valid_nxt = 1'b0;
      end
    end else if (w_wr) begin
      if (!r_main_valid) begin
        w_main_nxt       = in_beat;
        w_main_valid_nxt = 1'b1;
      end else begin
        w_skid_nxt       = in_beat;
        w_skid_valid_nxt = 1'b1;
      end
    end
  end

  // Entry registers; ready is held low through reset and tracks skid-empty after.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_main       <= '0;
      r_skid       <= '0;
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b0;
    end else begin
      r_main       <= w_main_nxt;
      r_skid       <= w_skid_nxt;
      r_main_valid <= w_main_valid_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_in_ready   <= !w_skid_valid_nxt;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_main_valid;
  assign out_beat  = r_main;

endmodule

// File: rtl/stream_demux.sv
// stream_demux: registered 1-to-2 stream demultiplexer with per-output skid stage.
// Macro STREAM_DEMUX_PKT_LOCK_EN: when defined, routing is locked for a whole
// packet (framed by c_last); when undefined, every beat routes by sel.
module stream_demux
  import stream_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               sel,
  input  logic [DATA_WD-1:0] c_data,
  input  logic               c_valid,
  input  logic               c_last,
  output logic               c_ready,
  output logic [DATA_WD-1:0] a_data,
  output logic               a_valid,
  output logic               a_last,
  input  logic               a_ready,
  output logic [DATA_WD-1:0] b_data,
  output logic               b_valid,
  output logic               b_last,
  input  logic               b_ready
);

  logic  w_route;
  logic  w_c_fire;
  logic  w_a_in_ready;
  logic  w_b_in_ready;
  beat_t w_c_beat;
  beat_t w_a_beat;
  beat_t w_b_beat;

`ifdef STREAM_DEMUX_PKT_LOCK_EN
  demux_state_t r_state;
  demux_state_t w_state_nxt;

  // Route follows sel only while no packet is in flight.
  assign w_route = lock_route(r_state, sel);

  // Lock state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Lock on the first beat of a multi-beat packet, release on its last beat.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_c_fire && !c_last) begin
          w_state_nxt = w_route ? LOCK_B : LOCK_A;
        end
      end
      LOCK_A, LOCK_B: begin
        if (w_c_fire && c_last) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end
`else
  assign w_route = sel;
`endif

  assign c_ready  = w_route ? w_b_in_ready : w_a_in_ready;
  assign w_c_fire = c_valid & c_ready;
  assign w_c_beat = '{last: c_last, data: c_data};

  stream_skid_buf u_skid_a (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (c_valid & !w_route),
    .in_ready  (w_a_in_ready),
    .in_beat   (w_c_beat),
    .out_valid (a_valid),
    .out_ready (a_ready),
    .out_beat  (w_a_beat)
  );

  stream_skid_buf u_skid_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (c_valid & w_route),
    .in_ready  (w_b_in_ready),
    .in_beat   (w_c_beat),
    .out_valid (b_valid),
    .out_ready (b_ready),
    .out_beat  (w_b_beat)
  );

  assign a_data = w_a_beat.data;
  assign a_last = w_a_beat.last;
  assign b_data = w_b_beat.data;
  assign b_last = w_b_beat.last;

endmodule

// File: tb/tb_stream_demux.sv
// tb_stream_demux: directed scoreboard bench for stream_demux.
// Routing expectations follow STREAM_DEMUX_PKT_LOCK_EN the same way as the design.
`timescale 1ns/1ps
module tb_stream_demux;
  import stream_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               sel;
  logic [DATA_WD-1:0] c_data;
  logic               c_valid;
  logic               c_last;
  logic               c_ready;
  logic [DATA_WD-1:0] a_data;
  logic               a_valid;
  logic               a_last;
  logic               a_ready;
  logic [DATA_WD-1:0] b_data;
  logic               b_valid;
  logic               b_last;
  logic               b_ready;

  typedef struct {
    logic               last;
    logic [DATA_WD-1:0] data;
    int                 at;
    bit                 chk_lat;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   m_lock = 0;

  stream_demux dut (
    .clk     (clk),
    .rst     (rst),
    .sel     (sel),
    .c_data  (c_data),
    .c_valid (c_valid),
    .c_last  (c_last),
    .c_ready (c_ready),
    .a_data  (a_data),
    .a_valid (a_valid),
    .a_last  (a_last),
    .a_ready (a_ready),
    .b_data  (b_data),
    .b_valid (b_valid),
    .b_last  (b_last),
    .b_ready (b_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference routing: lock model mirrors the packet framing, not the RTL.
  function automatic logic model_route(input logic s);
`ifdef STREAM_DEMUX_PKT_LOCK_EN
    if (m_lock == 1) return 1'b0;
    if (m_lock == 2) return 1'b1;
`endif
    return s;
  endfunction

  task automatic model_accept(input logic s, input logic [DATA_WD-1:0] d, input logic l, input bit lat);
    exp_t e;
    logic rt;
    rt = model_route(s);
    e = '{last: l, data: d, at: cyc, chk_lat: lat};
    if (rt) qb.push_back(e);
    else    qa.push_back(e);
`ifdef STREAM_DEMUX_PKT_LOCK_EN
    if (m_lock == 0) begin
      if (!l) m_lock = rt ? 2 : 1;
    end else if (l) begin
      m_lock = 0;
    end
`endif
  endtask

  // Offer one beat until accepted; called at posedge+1, returns at posedge+1.
  task automatic send(input logic s, input logic [DATA_WD-1:0] d, input logic l,
                      input bit lat, output int stalls);
    stalls = 0;
    sel = s; c_data = d; c_last = l; c_valid = 1'b1;
    @(negedge clk);
    while (!c_ready) begin
      stalls++;
      if (stalls > 40) begin
        checks++; errors++;
        $display("FAIL send_timeout: c_ready=%0b for beat %0h, required 1", c_ready, d);
        c_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    model_accept(s, d, l, lat);
    @(posedge clk); #1;
    c_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL drain: a pending=%0d b pending=%0d, required 0", qa.size(), qb.size());
    end
    @(posedge clk); #1;
  endtask

  // Output monitor: pops and compares whenever a port fires; checks hold under stall.
  task automatic monitor();
    exp_t             e;
    logic             a_stall = 1'b0;
    logic             b_stall = 1'b0;
    logic [DATA_WD:0] a_prev = '0;
    logic [DATA_WD:0] b_prev = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        a_stall = 1'b0;
        b_stall = 1'b0;
      end else begin
        if (a_stall) begin
          chk("a_hold_valid", a_valid, 1);
          chk("a_hold_beat", {a_last, a_data}, a_prev);
        end
        if (b_stall) begin
          chk("b_hold_valid", b_valid, 1);
          chk("b_hold_beat", {b_last, b_data}, b_prev);
        end
        if (a_valid && a_ready) begin
          if (qa.size() == 0) begin
            checks++; errors++;
            $display("FAIL a_unexpected: got beat %0h last %0b, required none", a_data, a_last);
          end else begin
            e = qa.pop_front();
            chk("a_data", a_data, e.data);
            chk("a_last", a_last, e.last);
            if (e.chk_lat) chk("a_latency", cyc, e.at + 1);
          end
        end
        if (b_valid && b_ready) begin
          if (qb.size() == 0) begin
            checks++; errors++;
            $display("FAIL b_unexpected: got beat %0h last %0b, required none", b_data, b_last);
          end else begin
            e = qb.pop_front();
            chk("b_data", b_data, e.data);
            chk("b_last", b_last, e.last);
            if (e.chk_lat) chk("b_latency", cyc, e.at + 1);
          end
        end
        a_stall = a_valid & !a_ready;
        b_stall = b_valid & !b_ready;
        a_prev  = {a_last, a_data};
        b_prev  = {b_last, b_data};
      end
    end
  endtask

  initial begin
    int st;
    int acc;
    int n;
    rst = 1'b1; c_valid = 1'b1; sel = 1'b0; c_data = 4'hF; c_last = 1'b0;
    a_ready = 1'b1; b_ready = 1'b1;
    fork
      monitor();
    join_none

    // Reset held for 3 cycles with c_valid high.
    repeat (3) begin
      @(negedge clk);
      chk("rst_c_ready", c_ready, 0);
      chk("rst_a_valid", a_valid, 0);
      chk("rst_b_valid", b_valid, 0);
    end
    chk("rst_a_data", {a_last, a_data}, 0);
    chk("rst_b_data", {b_last, b_data}, 0);
    @(posedge clk); #1;
    rst = 1'b0; c_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_release_c_ready", c_ready, 1);
    @(posedge clk); #1;

    // Packet lock: sel flips after beat 1; then a single beat to b proves IDLE.
    send(1'b0, 4'd1, 1'b0, 1'b0, st);
    send(1'b1, 4'd2, 1'b0, 1'b0, st);
    send(1'b1, 4'd3, 1'b0, 1'b0, st);
    send(1'b1, 4'd4, 1'b1, 1'b0, st);
    send(1'b1, 4'hE, 1'b1, 1'b0, st);
    wait_drain();

    // Streaming: alternating single-beat packets, one per cycle, 1-cycle latency.
    for (int i = 0; i < 3; i++) begin
      send(1'b0, 4'd5, 1'b1, 1'b1, st);
      chk("stream_stall_a", st, 0);
      send(1'b1, 4'd6, 1'b1, 1'b1, st);
      chk("stream_stall_b", st, 0);
    end
    wait_drain();

    // Backpressure: a stalled, 5 offer cycles, only 2 beats fit.
    a_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 5; k++) begin
      sel = 1'b0; c_data = 4'(7 + acc); c_last = 1'b1; c_valid = 1'b1;
      @(negedge clk);
      if (c_ready) begin
        model_accept(1'b0, c_data, 1'b1, 1'b0);
        acc++;
      end
      @(posedge clk); #1;
    end
    c_valid = 1'b0;
    chk("bp_accepted", acc, 2);
    @(negedge clk);
    chk("bp_c_ready", c_ready, 0);
    chk("bp_a_head", a_data, 7);
    @(posedge clk); #1;
    a_ready = 1'b1;
    send(1'b0, 4'd9, 1'b1, 1'b0, st);
    send(1'b0, 4'd10, 1'b1, 1'b0, st);
    send(1'b0, 4'd11, 1'b1, 1'b0, st);
    wait_drain();

    // Independence: b holds 2 beats while a packet flows through a.
    b_ready = 1'b0;
    send(1'b1, 4'd12, 1'b1, 1'b0, st);
    send(1'b1, 4'd13, 1'b1, 1'b0, st);
    send(1'b0, 4'd14, 1'b0, 1'b0, st);
    chk("ind_a_stall0", st, 0);
    send(1'b0, 4'd15, 1'b1, 1'b0, st);
    chk("ind_a_stall1", st, 0);
    n = 0;
    while (qa.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ind_a_drained", qa.size(), 0);
    @(negedge clk);
    chk("ind_b_valid", b_valid, 1);
    chk("ind_b_data", b_data, 12);
    @(posedge clk); #1;
    b_ready = 1'b1;
    wait_drain();

    // Mid-packet reset: buffered b beats and the lock are discarded.
    b_ready = 1'b0;
    send(1'b1, 4'd3, 1'b0, 1'b0, st);
    send(1'b1, 4'd4, 1'b0, 1'b0, st);
    rst = 1'b1; sel = 1'b0;
    qa.delete(); qb.delete(); m_lock = 0;
    @(posedge clk); #1;
    rst = 1'b0; b_ready = 1'b1;
    @(negedge clk);
    chk("mrst_b_valid", b_valid, 0);
    chk("mrst_a_valid", a_valid, 0);
    chk("mrst_b_data", b_data, 0);
    @(posedge clk); #1;
    send(1'b0, 4'd8, 1'b1, 1'b0, st);
    wait_drain();
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
